// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low glyph table, blank pattern and segment bit indices.
// Used by both the encoder and the decoder so the two ends agree on one table.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  // Bit positions within a pattern p[6:0] = {A,B,C,D,E,F,G}
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h01;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h12;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h4C;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h24;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h20;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h0F;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h00;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h04;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h08;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h60;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h31;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h42;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h38;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Outcome of one accept event
  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_GLYPH,
    ACC_BLANK,
    ACC_ERROR
  } accept_e;

endpackage

// File: rtl/seven_segment_pattern_lookup.sv
// Combinational reverse lookup: active-low segment pattern to hex nibble.
// hit is low when the pattern is not one of the 16 glyphs.
module seven_segment_pattern_lookup
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic             hit,
  output logic [3:0]       nibble
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    hit    = 1'b1;
    nibble = 4'h0;
    case (pattern)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Seven-segment receive side: synchronise, debounce, decode each new stable pattern.
// Optional saturating error counter on o_Err_Count when SEG_DEC_ERR_CNT_EN is defined.
module seven_segment_decoder
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Nibble,
  output logic       o_Valid,
  output logic       o_Error,
  output logic       o_Blank
`ifdef SEG_DEC_ERR_CNT_EN
  ,
  output logic [7:0] o_Err_Count
`endif
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [SEG_W-1:0] seg_raw;
  logic [SEG_W-1:0] sync_meta;
  logic [SEG_W-1:0] seg_sync;
  logic [SEG_W-1:0] prev_pat;
  logic [SEG_W-1:0] last_pat;
  logic [7:0]       stable_count;
  logic             same;
  logic             becomes_stable;
  logic             lut_hit;
  logic [3:0]       lut_nibble;
  accept_e          accept;

  assign seg_raw = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                    i_Segment_E, i_Segment_F, i_Segment_G};

  // Synchroniser and stability counter; resetting to blank means an idle bus never reports.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_meta    <= SEG_BLANK;
      seg_sync     <= SEG_BLANK;
      prev_pat     <= SEG_BLANK;
      stable_count <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      sync_meta <= seg_raw;
      seg_sync  <= sync_meta;
      prev_pat  <= seg_sync;
      if (!same)
        stable_count <= 8'd0;
      else if (stable_count != STABLE_MAX)
        stable_count <= stable_count + 8'd1;
    end
  end

  assign same           = (seg_sync == prev_pat);
  assign becomes_stable = same && (stable_count == STABLE_MAX - 8'd1);

  seven_segment_pattern_lookup u_lookup (
    .pattern (seg_sync),
    .hit     (lut_hit),
    .nibble  (lut_nibble)
  );

  always_comb begin
    accept = ACC_NONE;
    if (becomes_stable && (seg_sync != last_pat)) begin
      if (lut_hit)
        accept = ACC_GLYPH;
      else if (seg_sync == SEG_BLANK)
        accept = ACC_BLANK;
      else
        accept = ACC_ERROR;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      last_pat <= SEG_BLANK;
      o_Nibble <= 4'h0;
      o_Valid  <= 1'b0;
      o_Error  <= 1'b0;
      o_Blank  <= 1'b1;
    end else begin
      o_Valid <= (accept == ACC_GLYPH);
      o_Error <= (accept == ACC_ERROR);
      if (accept != ACC_NONE) begin
        last_pat <= seg_sync;
        o_Blank  <= (accept == ACC_BLANK);
      end
      if (accept == ACC_GLYPH)
        o_Nibble <= lut_nibble;
    end
  end

`ifdef SEG_DEC_ERR_CNT_EN
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)
      o_Err_Count <= 8'd0;
    else if ((accept == ACC_ERROR) && (o_Err_Count != 8'hFF))
      o_Err_Count <= o_Err_Count + 8'd1;
  end
`else
  // Error counter not built in this configuration.
`endif

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed self-checking bench for seven_segment_decoder (STABLE_CYCLES = 4).
// Error-counter checks are compiled in when SEG_DEC_ERR_CNT_EN is defined.
module tb_seven_segment_decoder;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic [3:0] nibble;
  logic       valid;
  logic       error;
  logic       blank;
`ifdef SEG_DEC_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seven_segment_decoder #(.STABLE_CYCLES(SC)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Segment_A (seg[6]),
    .i_Segment_B (seg[5]),
    .i_Segment_C (seg[4]),
    .i_Segment_D (seg[3]),
    .i_Segment_E (seg[2]),
    .i_Segment_F (seg[1]),
    .i_Segment_G (seg[0]),
    .o_Nibble    (nibble),
    .o_Valid     (valid),
    .o_Error     (error),
    .o_Blank     (blank)
`ifdef SEG_DEC_ERR_CNT_EN
    ,
    .o_Err_Count (err_count)
`endif
  );

  logic [6:0] glyph_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Results of the most recent watch() window
  int w_valid;
  int w_error;
  int w_first_valid;
  int w_first_error;
  bit w_both;

  // Called at a negedge: drive p, then observe for 'cycles' posedges (edge 0 = first one).
  task automatic watch(input logic [6:0] p, input int cycles);
    w_valid = 0; w_error = 0; w_first_valid = -1; w_first_error = -1; w_both = 0;
    seg = p;
    for (int e = 0; e < cycles; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) begin
        if (w_first_valid < 0) w_first_valid = e;
        w_valid++;
      end
      if (error) begin
        if (w_first_error < 0) w_first_error = e;
        w_error++;
      end
      if (valid && error) w_both = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    seg = 7'h7F;
    repeat (3) @(negedge clk);
    checks++; if (nibble !== 4'h0) begin failures++; $display("FAIL reset_nibble got=%h exp=0", nibble); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (blank !== 1'b1) begin failures++; $display("FAIL reset_blank got=%b exp=1", blank); end
`ifdef SEG_DEC_ERR_CNT_EN
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
`endif
    rst = 1'b0;
    watch(7'h7F, 10);
    checks++; if (w_valid != 0 || w_error != 0) begin failures++; $display("FAIL idle_blank_pulses valid=%0d error=%0d exp=0/0", w_valid, w_error); end
    checks++; if (blank !== 1'b1) begin failures++; $display("FAIL idle_blank_level got=%b exp=1", blank); end
    checks++; if (nibble !== 4'h0) begin failures++; $display("FAIL idle_nibble got=%h exp=0", nibble); end
  endtask

  task automatic test_glyphs();
    for (int v = 0; v < 16; v++) begin
      watch(glyph_tab[v], 10);
      checks++; if (w_valid != 1 || w_first_valid != SC + 2) begin
        failures++; $display("FAIL glyph_%0h_pulse count=%0d edge=%0d exp=1@%0d", v, w_valid, w_first_valid, SC + 2);
      end
      checks++; if (nibble !== 4'(v)) begin failures++; $display("FAIL glyph_%0h_nibble got=%h exp=%h", v, nibble, 4'(v)); end
      checks++; if (w_error != 0 || w_both) begin failures++; $display("FAIL glyph_%0h_error got=%0d exp=0", v, w_error); end
    end
    checks++; if (blank !== 1'b0) begin failures++; $display("FAIL glyph_blank_cleared got=%b exp=0", blank); end
  endtask

  task automatic test_glitch();
    watch(7'h12, 10);
    checks++; if (w_valid != 1 || nibble !== 4'h2) begin failures++; $display("FAIL glitch_setup valid=%0d nibble=%h exp=1/2", w_valid, nibble); end
    watch(7'h00, 3);
    checks++; if (w_valid != 0 || w_error != 0) begin failures++; $display("FAIL glitch_during valid=%0d error=%0d exp=0/0", w_valid, w_error); end
    watch(7'h12, 10);
    checks++; if (w_valid != 0 || w_error != 0) begin failures++; $display("FAIL glitch_return valid=%0d error=%0d exp=0/0", w_valid, w_error); end
    checks++; if (nibble !== 4'h2) begin failures++; $display("FAIL glitch_nibble got=%h exp=2", nibble); end
  endtask

  task automatic test_error();
    watch(7'h55, 10);
    checks++; if (w_error != 1 || w_first_error != SC + 2) begin
      failures++; $display("FAIL error_pulse count=%0d edge=%0d exp=1@%0d", w_error, w_first_error, SC + 2);
    end
    checks++; if (w_valid != 0) begin failures++; $display("FAIL error_valid got=%0d exp=0", w_valid); end
    checks++; if (nibble !== 4'h2) begin failures++; $display("FAIL error_nibble got=%h exp=2", nibble); end
    checks++; if (blank !== 1'b0) begin failures++; $display("FAIL error_blank got=%b exp=0", blank); end
`ifdef SEG_DEC_ERR_CNT_EN
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL error_count got=%0d exp=1", err_count); end
`endif
  endtask

  task automatic test_blank();
    watch(7'h7F, 10);
    checks++; if (w_valid != 0 || w_error != 0) begin failures++; $display("FAIL blank_pulses valid=%0d error=%0d exp=0/0", w_valid, w_error); end
    checks++; if (blank !== 1'b1) begin failures++; $display("FAIL blank_set got=%b exp=1", blank); end
    watch(7'h06, 10);
    checks++; if (w_valid != 1 || nibble !== 4'h3 || blank !== 1'b0) begin
      failures++; $display("FAIL blank_clear valid=%0d nibble=%h blank=%b exp=1/3/0", w_valid, nibble, blank);
    end
  endtask

  task automatic test_err_saturation();
    int tot_err = 0;
    int tot_val = 0;
    for (int i = 0; i < 300; i++) begin
      watch(7'h55, 8);
      tot_err += w_error; tot_val += w_valid;
      watch(glyph_tab[i % 16], 8);
      tot_err += w_error; tot_val += w_valid;
    end
    checks++; if (tot_err != 300 || tot_val != 300) begin
      failures++; $display("FAIL alternation_pulses errors=%0d valids=%0d exp=300/300", tot_err, tot_val);
    end
    checks++; if (nibble !== 4'hB) begin failures++; $display("FAIL alternation_nibble got=%h exp=b", nibble); end
`ifdef SEG_DEC_ERR_CNT_EN
    checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL err_count_saturate got=%0d exp=255", err_count); end
`endif
  endtask

  task automatic test_reset_mid();
    seg = 7'h4F;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (nibble !== 4'h0 || valid !== 1'b0 || error !== 1'b0 || blank !== 1'b1) begin
      failures++; $display("FAIL midreset_outputs nibble=%h valid=%b error=%b blank=%b exp=0/0/0/1", nibble, valid, error, blank);
    end
`ifdef SEG_DEC_ERR_CNT_EN
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL midreset_err_count got=%0d exp=0", err_count); end
`endif
    @(negedge clk);
    rst = 1'b0;
    watch(7'h4F, 10);
    checks++; if (w_valid != 1 || w_first_valid != SC + 2 || nibble !== 4'h1) begin
      failures++; $display("FAIL midreset_recover count=%0d edge=%0d nibble=%h exp=1@%0d/1", w_valid, w_first_valid, nibble, SC + 2);
    end
  endtask

  task automatic test_hold();
    watch(7'h06, 50);
    checks++; if (w_valid != 1 || w_error != 0 || nibble !== 4'h3) begin
      failures++; $display("FAIL hold_single valid=%0d error=%0d nibble=%h exp=1/0/3", w_valid, w_error, nibble);
    end
  endtask

  task automatic test_filter_boundary();
    watch(7'h0F, SC);
    checks++; if (w_valid != 0) begin failures++; $display("FAIL short_glitch_valid got=%0d exp=0", w_valid); end
    watch(7'h06, 10);
    checks++; if (w_valid != 0 || nibble !== 4'h3) begin failures++; $display("FAIL short_glitch_return valid=%0d nibble=%h exp=0/3", w_valid, nibble); end
    watch(7'h0F, SC + 1);
    watch(7'h06, 12);
    checks++; if (w_valid != 2 || w_first_valid != 1) begin
      failures++; $display("FAIL min_width_accept count=%0d first=%0d exp=2@1", w_valid, w_first_valid);
    end
    checks++; if (nibble !== 4'h3) begin failures++; $display("FAIL min_width_nibble got=%h exp=3", nibble); end
  endtask

  initial begin
    rst = 1'b1;
    seg = 7'h7F;
    @(negedge clk);
    test_reset();
    test_glyphs();
    test_glitch();
    test_error();
    test_blank();
    test_err_saturation();
    test_reset_mid();
    test_hold();
    test_filter_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
